// File: rtl/ad9648_pkg.sv
// Shared encodings and constant generators for the ADC channel mux/demux pair.
// No logic of its own; imported by the mux and its FIFO users.
package ad9648_pkg;

    typedef enum logic [1:0] {
        MODE_NORMAL   = 2'd0,
        MODE_MIDSCALE = 2'd1,
        MODE_CHECKER  = 2'd2,
        MODE_RAMP     = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEND_A = 2'd1,
        ST_SEND_B = 2'd2
    } state_e;

    // Channel A checkerboard: odd bits set (0b1010...).
    function automatic logic [31:0] checker_a(int res);
        logic [31:0] r;
        r = '0;
        for (int i = 1; i < res; i += 2) r[i] = 1'b1;
        return r;
    endfunction

    // Channel B checkerboard: even bits set (0b0101...).
    function automatic logic [31:0] checker_b(int res);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < res; i += 2) r[i] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/pair_fifo.sv
// Synchronous FIFO with show-ahead read data; depth must be a power of two >= 2.
// Latency: written entry visible one clock after push. Backpressure: push ignored when full.
module pair_fifo #(
    parameter int Width = 28,
    parameter int Depth = 4
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             push_vld,
    input  logic [Width-1:0] push_dat,
    input  logic             pop,
    output logic [Width-1:0] pop_dat,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(Depth);

    logic [Width-1:0] mem [Depth];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Extra pointer MSB distinguishes full from empty when indices match.
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty   = (wr_ptr == rd_ptr);
    assign do_push = push_vld && !full;
    assign do_pop  = pop && !empty;
    assign pop_dat = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_dat;
    end

endmodule

// File: rtl/adc_channel_mux.sv
// Interleaves buffered A/B sample pairs into one word stream (A then B), with ADC test patterns.
// Latency: pair pushed into an empty FIFO while idle gives A one clock later. Backpressure: s_ready_o low while FIFO full.
module adc_channel_mux
    import ad9648_pkg::*;
#(
    parameter int AdcRes    = 14,
    parameter int FifoDepth = 4
) (
    input  logic              clk_mux_i,
    input  logic              rst_n_i,
    input  logic [1:0]        mode_i,
    input  logic              s_valid_i,
    output logic              s_ready_o,
    input  logic [AdcRes-1:0] ch_A_i,
    input  logic [AdcRes-1:0] ch_B_i,
    output logic              valid_o,
    output logic              phase_o,
    output logic [AdcRes-1:0] adc_data_o,
    output logic [15:0]       gap_cnt_o
);

    localparam logic [AdcRes-1:0] MID_VAL = {1'b1, {(AdcRes-1){1'b0}}};
    localparam logic [AdcRes-1:0] CHK_A   = AdcRes'(checker_a(AdcRes));
    localparam logic [AdcRes-1:0] CHK_B   = AdcRes'(checker_b(AdcRes));

    state_e              state_q, state_d;
    logic                valid_q, valid_d;
    logic                phase_q, phase_d;
    logic [AdcRes-1:0]   data_q, data_d;
    logic [AdcRes-1:0]   b_hold_q, b_hold_d;
    logic [AdcRes-1:0]   ramp_q, ramp_d;
    mode_e               last_mode_q, last_mode_d;
    logic [15:0]         gap_q, gap_d;

    mode_e               mode_s;
    logic                fifo_full;
    logic                fifo_empty;
    logic                fifo_pop;
    logic [2*AdcRes-1:0] fifo_dat;
    logic                pair_avail;
    logic [AdcRes-1:0]   ramp_base;
    logic [AdcRes-1:0]   a_sel;
    logic [AdcRes-1:0]   b_sel;

    assign mode_s     = mode_e'(mode_i);
    assign s_ready_o  = !fifo_full;
    assign pair_avail = (mode_s != MODE_NORMAL) || !fifo_empty;
    // Ramp restarts from zero whenever the previous pair was not a ramp pair.
    assign ramp_base  = (last_mode_q == MODE_RAMP) ? ramp_q : '0;

    pair_fifo #(
        .Width(2 * AdcRes),
        .Depth(FifoDepth)
    ) u_pair_fifo (
        .clk_i    (clk_mux_i),
        .rst_n_i  (rst_n_i),
        .push_vld (s_valid_i),
        .push_dat ({ch_A_i, ch_B_i}),
        .pop      (fifo_pop),
        .pop_dat  (fifo_dat),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    always_comb begin
        a_sel = fifo_dat[2*AdcRes-1:AdcRes];
        b_sel = fifo_dat[AdcRes-1:0];
        case (mode_s)
            MODE_MIDSCALE: begin
                a_sel = MID_VAL;
                b_sel = MID_VAL;
            end
            MODE_CHECKER: begin
                a_sel = CHK_A;
                b_sel = CHK_B;
            end
            MODE_RAMP: begin
                a_sel = ramp_base;
                b_sel = ramp_base + AdcRes'(1);
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        valid_d     = valid_q;
        phase_d     = phase_q;
        data_d      = data_q;
        b_hold_d    = b_hold_q;
        ramp_d      = ramp_q;
        last_mode_d = last_mode_q;
        gap_d       = gap_q;
        fifo_pop    = 1'b0;
        case (state_q)
            ST_SEND_A: begin
                state_d = ST_SEND_B;
                valid_d = 1'b1;
                phase_d = 1'b1;
                data_d  = b_hold_q;
            end
            default: begin
                if (pair_avail) begin
                    // Mode is captured here; B of this pair comes from b_hold regardless of later mode changes.
                    state_d     = ST_SEND_A;
                    valid_d     = 1'b1;
                    phase_d     = 1'b0;
                    data_d      = a_sel;
                    b_hold_d    = b_sel;
                    last_mode_d = mode_s;
                    fifo_pop    = (mode_s == MODE_NORMAL);
                    if (mode_s == MODE_RAMP) ramp_d = ramp_base + AdcRes'(2);
                end else begin
                    state_d = ST_IDLE;
                    valid_d = 1'b0;
                    phase_d = 1'b0;
                    if (state_q == ST_SEND_B && gap_q != 16'hFFFF) gap_d = gap_q + 16'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clk_mux_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= ST_IDLE;
            valid_q     <= 1'b0;
            phase_q     <= 1'b0;
            data_q      <= '0;
            b_hold_q    <= '0;
            ramp_q      <= '0;
            last_mode_q <= MODE_NORMAL;
            gap_q       <= '0;
        end else begin
            state_q     <= state_d;
            valid_q     <= valid_d;
            phase_q     <= phase_d;
            data_q      <= data_d;
            b_hold_q    <= b_hold_d;
            ramp_q      <= ramp_d;
            last_mode_q <= last_mode_d;
            gap_q       <= gap_d;
        end
    end

    assign valid_o    = valid_q;
    assign phase_o    = phase_q;
    assign adc_data_o = data_q;
    assign gap_cnt_o  = gap_q;

endmodule
